// File: rtl/nrzi_dec.sv
// NRZI line decoder with bit de-stuffing and LSB-first byte assembly.
// Latency: dout/dout_valid and stuff_err appear one cycle after the deciding sample.
// Backpressure: none; one sample is accepted every cycle din_valid is high.
module nrzi_dec #(
    parameter int   STUFF_LEN  = 6,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din,
    input  logic       align,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       stuff_err
);

    localparam int            CW       = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] ONES_MAX = CW'(STUFF_LEN);

    typedef enum logic {
        S_DATA,
        S_STUFF
    } state_t;

    state_t        state, state_nx;
    logic          prev_level, prev_level_nx;
    logic [CW-1:0] ones_cnt, ones_cnt_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    dout_nx;
    logic          dout_valid_nx;
    logic          stuff_err_nx;

    logic          dec_bit;
    logic [2:0]    base_bit;
    logic [CW-1:0] base_ones;
    logic [CW-1:0] ones_inc;
    logic          in_stuff;

    // align restarts the byte, so a sample arriving with it sees fresh counters
    assign dec_bit   = (din == prev_level);
    assign base_bit  = align ? 3'd0 : bit_cnt;
    assign base_ones = align ? '0 : ones_cnt;
    assign ones_inc  = base_ones + 1'b1;
    assign in_stuff  = (state == S_STUFF) && !align;

    always_comb begin
        state_nx      = state;
        prev_level_nx = prev_level;
        ones_cnt_nx   = base_ones;
        bit_cnt_nx    = base_bit;
        shift_nx      = shift;
        dout_nx       = dout;
        dout_valid_nx = 1'b0;
        stuff_err_nx  = 1'b0;

        if (align) begin
            state_nx = S_DATA;
        end

        if (din_valid) begin
            prev_level_nx = din;
            if (in_stuff) begin
                // stuffed position: the bit itself is dropped, a 1 here is a violation
                state_nx    = S_DATA;
                ones_cnt_nx = '0;
                if (dec_bit) begin
                    stuff_err_nx = 1'b1;
                    bit_cnt_nx   = 3'd0;
                end
            end else begin
                shift_nx   = {dec_bit, shift[7:1]};
                bit_cnt_nx = base_bit + 3'd1;
                if (dec_bit) begin
                    ones_cnt_nx = ones_inc;
                    if (ones_inc == ONES_MAX) begin
                        state_nx = S_STUFF;
                    end
                end else begin
                    ones_cnt_nx = '0;
                end
                if (base_bit == 3'd7) begin
                    dout_nx       = {dec_bit, shift[7:1]};
                    dout_valid_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_DATA;
            prev_level <= IDLE_LEVEL;
            ones_cnt   <= '0;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            prev_level <= prev_level_nx;
            ones_cnt   <= ones_cnt_nx;
            bit_cnt    <= bit_cnt_nx;
            shift      <= shift_nx;
            dout       <= dout_nx;
            dout_valid <= dout_valid_nx;
            stuff_err  <= stuff_err_nx;
        end
    end

endmodule

// File: tb/tb_nrzi_dec.sv
// Bench for nrzi_dec: directed scenarios plus biased random traffic against a bit-stream model.
module tb_nrzi_dec;

    localparam int STUFF_LEN = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       din = 1'b1;
    logic       align = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       stuff_err;

    nrzi_dec #(.STUFF_LEN(STUFF_LEN), .IDLE_LEVEL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .align      (align),
        .dout       (dout),
        .dout_valid (dout_valid),
        .stuff_err  (stuff_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int seen_vld;
    int seen_err;

    // Reference: line level, run length of decoded ones, pending partial byte as a bit list
    logic       m_prev;
    int         m_ones;
    logic       m_expect_stuff;
    logic       m_bits[$];
    logic [7:0] m_dout;
    logic       exp_vld;
    logic       exp_err;

    logic a5_line [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic model_reset();
        m_prev         = 1'b1;
        m_ones         = 0;
        m_expect_stuff = 1'b0;
        m_bits.delete();
        m_dout         = 8'h00;
        exp_vld        = 1'b0;
        exp_err        = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic a);
        logic b;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (a) begin
            m_ones         = 0;
            m_expect_stuff = 1'b0;
            m_bits.delete();
        end
        if (v) begin
            b      = (d == m_prev);
            m_prev = d;
            if (m_expect_stuff) begin
                m_expect_stuff = 1'b0;
                m_ones         = 0;
                if (b) begin
                    exp_err = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_ones = b ? m_ones + 1 : 0;
                m_bits.push_back(b);
                if (m_bits.size() == 8) begin
                    m_dout = 8'h00;
                    for (int i = 0; i < 8; i++) m_dout = m_dout | (8'(m_bits[i]) << i);
                    exp_vld = 1'b1;
                    m_bits.delete();
                end
                if (m_ones == STUFF_LEN) m_expect_stuff = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic d, input logic a);
        @(negedge clk);
        rst       = r;
        din_valid = v;
        din       = d;
        align     = a;
        if (r) model_reset();
        else   model_step(v, d, a);
        @(posedge clk);
        #1;
        check("dout_valid", {7'b0, dout_valid}, {7'b0, exp_vld});
        check("stuff_err", {7'b0, stuff_err}, {7'b0, exp_err});
        check("dout", dout, m_dout);
        check("strobe_exclusive", {7'b0, dout_valid & stuff_err}, 8'h00);
        if (dout_valid) seen_vld++;
        if (stuff_err)  seen_err++;
    endtask

    task automatic sample(input logic d);
        cycle(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        seen_vld = 0;
        seen_err = 0;
    endtask

    initial begin
        logic d;
        int   gap;

        // Reset state and idle hold
        do_reset();
        check("reset_dout", dout, 8'h00);
        idle(10);
        check("idle_dout", dout, 8'h00);
        check("idle_strobes", 8'(seen_vld + seen_err), 8'h00);

        // Plain byte A5
        do_reset();
        for (int i = 0; i < 8; i++) sample(a5_line[i]);
        check("a5_dout", dout, 8'hA5);
        check("a5_count", 8'(seen_vld), 8'd1);
        idle(3);
        check("a5_hold", dout, 8'hA5);

        // Six ones, stuffed zero, then two more ones -> FF
        do_reset();
        for (int i = 0; i < 6; i++) sample(1'b1);
        sample(1'b0);
        check("stuff_no_byte_yet", 8'(seen_vld), 8'd0);
        sample(1'b0);
        sample(1'b0);
        check("ff_dout", dout, 8'hFF);
        check("ff_count", 8'(seen_vld), 8'd1);
        check("ff_no_err", 8'(seen_err), 8'd0);

        // Seven ones -> stuffing violation, then recover with A5
        do_reset();
        for (int i = 0; i < 7; i++) sample(1'b1);
        check("err_count", 8'(seen_err), 8'd1);
        check("err_no_byte", 8'(seen_vld), 8'd0);
        for (int i = 0; i < 8; i++) sample(a5_line[i]);
        check("err_recover_dout", dout, 8'hA5);
        check("err_recover_count", 8'(seen_vld), 8'd1);

        // A5 with idle gaps between samples
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sample(a5_line[i]);
            gap = $urandom_range(1, 3);
            idle(gap);
        end
        check("gap_dout", dout, 8'hA5);
        check("gap_count", 8'(seen_vld), 8'd1);

        // Three stray samples, then align with the first A5 sample
        do_reset();
        sample(1'b1);
        sample(1'b0);
        sample(1'b1);
        cycle(1'b0, 1'b1, a5_line[0], 1'b1);
        for (int i = 1; i < 8; i++) sample(a5_line[i]);
        check("align_dout", dout, 8'hA5);
        check("align_count", 8'(seen_vld), 8'd1);

        // Sixth one lands on the byte boundary: byte FC, then the stuffed zero is consumed
        do_reset();
        sample(1'b0);
        sample(1'b1);
        for (int i = 0; i < 6; i++) sample(1'b1);
        check("boundary_dout", dout, 8'hFC);
        check("boundary_count", 8'(seen_vld), 8'd1);
        sample(1'b0);
        check("boundary_stuff_ok", 8'(seen_err), 8'd0);

        // Reset mid-byte drops the partial byte silently
        do_reset();
        for (int i = 0; i < 5; i++) sample(a5_line[i]);
        do_reset();
        for (int i = 5; i < 8; i++) sample(a5_line[i]);
        idle(2);
        check("midreset_no_byte", 8'(seen_vld), 8'd0);
        check("midreset_dout", dout, 8'h00);

        // Random traffic, biased toward long runs of decoded ones
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            d = ($urandom_range(0, 99) < 80) ? m_prev : ~m_prev;
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < 75),
                  d,
                  ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
